qam16_demapper_rx: RTL

- 16-QAM receive demapper; the decoding counterpart of the 16-QAM TX mapper.
- Takes the downsampled in-phase and quadrature decision variables, one per symbol.
- Tracks an adaptive per-rail reference level, slices each rail to 2 bits, reassembles the 4-bit symbol and produces per-rail decision error.
- Sits after the downsamplers, replacing the separate single-rail ref-level/slicer/mapper chain.

---
 rtl/qam16_demapper_rx.sv | 327 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/qam16_demapper_rx.sv
// ---------------------------------------------------------------------------
// qam16_demapper_rx
//
// 16-QAM receive demapper. Takes one in-phase and one quadrature decision
// variable per symbol (qualified by sym_clk_en), tracks an adaptive
// reference level "a" per rail, slices each rail to two bits, reassembles
// the 4-bit symbol and reports the per-rail decision error.
//
// Per-rail map : 00 -> +3a, 01 -> +a, 11 -> -a, 10 -> -3a
// Thresholds   : 0 and +/-2a, ties go to the more positive symbol. With
//                a == 0 only 01 / 11 can be decided.
//
// Pipeline     : stage 1 (symbol n)   slice, register sym_out, pulse
//                                     sym_valid, keep x and its level
//                stage 2 (symbol n+1) err = x - level, saturated to 18 bits
//
// Reference    : sum |x| over 2^WIN_LOG2 non-hold symbols; at the window
//                wrap a = sum >> (WIN_LOG2+1) because mean|x| = 2a for an
//                evenly used constellation. Until the first wrap the rails
//                slice against ref_init.
//
// Optional     : define QAM16_ERR_CNT_EN to build the per-window symbol
//                mismatch counter (decision vs exp_data). Without it
//                err_cnt is tied to zero and exp_data is ignored.
//
// Handshake    : there is no backpressure. sym_clk_en is a one-clk strobe
//                that qualifies every input for exactly one symbol;
//                sym_valid is a one-clk strobe, one clk after the accepted
//                strobe, marking the cycle sym_out took its new value.
// ---------------------------------------------------------------------------
module qam16_demapper_rx #(
   parameter int WIN_LOG2  = 6,
   parameter int ERR_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sym_clk_en,
   input  logic                  hold,
   input  logic signed [17:0]    ref_init,
   input  logic signed [17:0]    in_inph,
   input  logic signed [17:0]    in_quad,
   input  logic [3:0]            exp_data,
   output logic [3:0]            sym_out,
   output logic                  sym_valid,
   output logic signed [17:0]    ref_inph,
   output logic signed [17:0]    ref_quad,
   output logic signed [17:0]    err_inph,
   output logic signed [17:0]    err_quad,
   output logic                  locked,
   output logic [ERR_CNT_W-1:0]  err_cnt,
   output logic                  state_dbg
);

   // accumulator is wide enough for 2^WIN_LOG2 full-scale magnitudes
   localparam int ACC_W = 18 + WIN_LOG2;

   localparam logic signed [17:0] S18_MAX = 18'sh1FFFF;
   localparam logic signed [17:0] S18_MIN = 18'sh20000;
   localparam logic signed [20:0] S21_MAX = 21'sd131071;
   localparam logic signed [20:0] S21_MIN = -21'sd131072;

   localparam logic [WIN_LOG2-1:0] CNT_ONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};
   localparam logic [WIN_LOG2-1:0] CNT_MAX = {WIN_LOG2{1'b1}};

   typedef enum logic {
      ACQ   = 1'b0,
      TRACK = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------------

   // |x| as a 17-bit magnitude; the most negative input clips to 131071
   function automatic logic [16:0] abs_sat(input logic signed [17:0] x);
      logic signed [17:0] n;
      logic [16:0]        m;
      n = -x;
      if (x == S18_MIN)  m = 17'h1FFFF;
      else if (x[17])    m = n[16:0];
      else               m = x[16:0];
      return m;
   endfunction

   // two-bit decision for one rail against reference level a
   function automatic logic [1:0] slice_rail(input logic signed [17:0] x,
                                             input logic signed [17:0] a);
      logic signed [19:0] xw;
      logic signed [19:0] two_a;
      logic [1:0]         b;
      xw    = {{2{x[17]}}, x};
      two_a = {a[17], a, 1'b0};
      if (a == 18'sd0)          b = x[17] ? 2'b11 : 2'b01;
      else if (xw >= two_a)     b = 2'b00;
      else if (!x[17])          b = 2'b01;
      else if (xw >= -two_a)    b = 2'b11;
      else                      b = 2'b10;
      return b;
   endfunction

   // constellation level for a two-bit decision, kept at 21 bits so 3a
   // never wraps for any 18-bit a
   function automatic logic signed [20:0] remap_rail(input logic [1:0]         b,
                                                     input logic signed [17:0] a);
      logic signed [20:0] aw;
      logic signed [20:0] a3;
      logic signed [20:0] lvl;
      aw = {{3{a[17]}}, a};
      a3 = aw + (aw <<< 1);
      case (b)
         2'b00:   lvl = a3;
         2'b01:   lvl = aw;
         2'b11:   lvl = -aw;
         default: lvl = -a3;
      endcase
      return lvl;
   endfunction

   // clip a 21-bit difference into the 18-bit output range
   function automatic logic signed [17:0] sat18(input logic signed [20:0] v);
      logic signed [17:0] r;
      if (v > S21_MAX)       r = S18_MAX;
      else if (v < S21_MIN)  r = S18_MIN;
      else                   r = v[17:0];
      return r;
   endfunction

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   state_t                state;
   logic                  ref_loaded;
   logic signed [17:0]    ref_i_q;
   logic signed [17:0]    ref_q_q;
   logic [WIN_LOG2-1:0]   win_cnt;
   logic [ACC_W-1:0]      acc_i;
   logic [ACC_W-1:0]      acc_q;

   logic signed [17:0]    x_i_d;
   logic signed [17:0]    x_q_d;
   logic signed [20:0]    dec_i_d;
   logic signed [20:0]    dec_q_d;

   // -------------------------------------------------------------------------
   // Combinational datapath
   // -------------------------------------------------------------------------
   logic signed [17:0]    a_i_eff;
   logic signed [17:0]    a_q_eff;
   logic [1:0]            bits_i;
   logic [1:0]            bits_q;
   logic signed [20:0]    lvl_i;
   logic signed [20:0]    lvl_q;
   logic [16:0]           mag_i;
   logic [16:0]           mag_q;
   logic [ACC_W-1:0]      acc_i_nxt;
   logic [ACC_W-1:0]      acc_q_nxt;
   logic signed [17:0]    ref_i_new;
   logic signed [17:0]    ref_q_new;
   logic signed [20:0]    diff_i;
   logic signed [20:0]    diff_q;
   logic                  count_en;
   logic                  win_last;
   logic                  wrap;

   // before the first strobe the register has not yet captured ref_init
   assign a_i_eff   = ref_loaded ? ref_i_q : ref_init;
   assign a_q_eff   = ref_loaded ? ref_q_q : ref_init;

   assign bits_i    = slice_rail(in_inph, a_i_eff);
   assign bits_q    = slice_rail(in_quad, a_q_eff);
   assign lvl_i     = remap_rail(bits_i, a_i_eff);
   assign lvl_q     = remap_rail(bits_q, a_q_eff);

   assign mag_i     = abs_sat(in_inph);
   assign mag_q     = abs_sat(in_quad);
   assign acc_i_nxt = acc_i + ACC_W'(mag_i);
   assign acc_q_nxt = acc_q + ACC_W'(mag_q);

   // sum >> (WIN_LOG2+1) leaves 17 significant bits, always non-negative
   assign ref_i_new = {1'b0, acc_i_nxt[ACC_W-1 -: 17]};
   assign ref_q_new = {1'b0, acc_q_nxt[ACC_W-1 -: 17]};

   assign diff_i    = {{3{x_i_d[17]}}, x_i_d} - dec_i_d;
   assign diff_q    = {{3{x_q_d[17]}}, x_q_d} - dec_q_d;

   // hold freezes the window, so a wrap under hold slides to the next
   // non-hold symbol automatically
   assign count_en  = sym_clk_en & ~hold;
   assign win_last  = (win_cnt == CNT_MAX);
   assign wrap      = count_en & win_last;

   // -------------------------------------------------------------------------
   // Sequential logic
   // -------------------------------------------------------------------------

   // Stage 1: register the decision and keep x plus its level for stage 2
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sym_out   <= 4'b0000;
         sym_valid <= 1'b0;
         x_i_d     <= '0;
         x_q_d     <= '0;
         dec_i_d   <= '0;
         dec_q_d   <= '0;
      end else begin
         sym_valid <= sym_clk_en;
         if (sym_clk_en) begin
            sym_out <= {bits_q, bits_i};
            x_i_d   <= in_inph;
            x_q_d   <= in_quad;
            dec_i_d <= lvl_i;
            dec_q_d <= lvl_q;
         end
      end
   end

   // Stage 2: decision error of the previous symbol, clipped to 18 bits
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_inph <= '0;
         err_quad <= '0;
      end else if (sym_clk_en) begin
         err_inph <= sat18(diff_i);
         err_quad <= sat18(diff_q);
      end
   end

   // Window accumulation and reference update at each window wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt    <= '0;
         acc_i      <= '0;
         acc_q      <= '0;
         ref_i_q    <= '0;
         ref_q_q    <= '0;
         ref_loaded <= 1'b0;
      end else if (sym_clk_en) begin
         if (!ref_loaded) begin
            ref_i_q    <= ref_init;
            ref_q_q    <= ref_init;
            ref_loaded <= 1'b1;
         end
         if (!hold) begin
            win_cnt <= win_cnt + CNT_ONE;
            if (win_last) begin
               acc_i      <= '0;
               acc_q      <= '0;
               ref_i_q    <= ref_i_new;
               ref_q_q    <= ref_q_new;
               ref_loaded <= 1'b1;
            end else begin
               acc_i <= acc_i_nxt;
               acc_q <= acc_q_nxt;
            end
         end
      end
   end

   // Acquisition FSM: leave ACQ at the first completed window, lock forever
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ACQ;
         locked <= 1'b0;
      end else begin
         case (state)
            ACQ: begin
               if (wrap) begin
                  state  <= TRACK;
                  locked <= 1'b1;
               end
            end
            TRACK: begin
               locked <= 1'b1;
            end
            default: begin
               state  <= ACQ;
               locked <= 1'b0;
            end
         endcase
      end
   end

   assign ref_inph  = ref_i_q;
   assign ref_quad  = ref_q_q;
   assign state_dbg = (state == TRACK);

   // -------------------------------------------------------------------------
   // Optional per-window symbol mismatch counter
   // -------------------------------------------------------------------------
`ifdef QAM16_ERR_CNT_EN
   logic [ERR_CNT_W-1:0] run_cnt;
   logic [ERR_CNT_W-1:0] run_nxt;
   logic [ERR_CNT_W-1:0] err_cnt_q;
   logic                 mism;

   assign mism = ({bits_q, bits_i} != exp_data);

   // running count including the current symbol, clipped at all-ones
   always_comb begin
      run_nxt = run_cnt;
      if (mism && (run_cnt != {ERR_CNT_W{1'b1}}))
         run_nxt = run_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
   end

   // Count mismatches on non-hold symbols; publish and restart at each wrap
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         run_cnt   <= '0;
         err_cnt_q <= '0;
      end else if (count_en) begin
         if (win_last) begin
            err_cnt_q <= run_nxt;
            run_cnt   <= '0;
         end else begin
            run_cnt <= run_nxt;
         end
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_exp_data;
   assign unused_exp_data = ^exp_data;
   assign err_cnt         = '0;
`endif

endmodule
